// File: rtl/dmem_pkg.sv
// Shared types and request-legality helpers for the dmem_responder slice.
// Sizes are byte counts; only 1, 2, 4 and 8 are legal transfers.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] SIZE_B = 4'd1;
  localparam logic [3:0] SIZE_H = 4'd2;
  localparam logic [3:0] SIZE_W = 4'd4;
  localparam logic [3:0] SIZE_D = 4'd8;

  function automatic logic size_legal(input logic [3:0] size);
    return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W) || (size == SIZE_D);
  endfunction

  // Only meaningful for legal sizes: size 8 has low bits 000, so size-1 wraps to 111.
  function automatic logic addr_aligned(input logic [2:0] addr_lo, input logic [2:0] size_lo);
    return (addr_lo & (size_lo - 3'd1)) == 3'd0;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [3:0] size);
    logic [7:0] m;
    m = 8'h00;
    case (size)
      SIZE_B:  m = 8'h01;
      SIZE_H:  m = 8'h03;
      SIZE_W:  m = 8'h0F;
      SIZE_D:  m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] data_mask(input logic [3:0] size);
    logic [63:0] m;
    m = '0;
    case (size)
      SIZE_B:  m = 64'h0000_0000_0000_00FF;
      SIZE_H:  m = 64'h0000_0000_0000_FFFF;
      SIZE_W:  m = 64'h0000_0000_FFFF_FFFF;
      SIZE_D:  m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressable storage organised as 8-byte little-endian rows with per-lane
// write enables and a synchronous whole-array clear.
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  localparam int ADDR_W = $clog2(DEPTH_BYTES),
  localparam int ROW_W  = (ADDR_W > 3) ? ADDR_W - 3 : 1,
  localparam int ROWS   = DEPTH_BYTES / 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [ROW_W-1:0] row,
  input  logic [7:0]       byte_en,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] mem_q [ROWS];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int r = 0; r < ROWS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) begin
          mem_q[row][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[row];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts a load/store, performs it on
// the accept edge, and presents the registered result after LATENCY edges.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int ADDR_W = $clog2(DEPTH_BYTES);
  localparam int ROW_W  = (ADDR_W > 3) ? ADDR_W - 3 : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             req_err;
  logic [5:0]       lane_shift;
  logic [ROW_W-1:0] row_idx;
  logic [7:0]       byte_en;
  logic [63:0]      lane_wdata;
  logic [63:0]      row_rdata;
  logic [63:0]      load_data;

  logic [63:0]      rsp_rdata_p1;
  logic             rsp_err_p1;

  assign accept = (state_q == IDLE) && req_valid;

  // End-of-transfer check is done in 65 bits so addresses near 2^64 cannot wrap into range.
  assign req_err = !size_legal(req_size)
                || !addr_aligned(req_addr[2:0], req_size[2:0])
                || (({1'b0, req_addr} + {61'd0, req_size}) > 65'(DEPTH_BYTES));

  assign lane_shift = {req_addr[2:0], 3'b000};
  assign row_idx    = ROW_W'(req_addr >> 3);
  assign byte_en    = (accept && req_write && !req_err) ? (lane_mask(req_size) << req_addr[2:0]) : 8'h00;
  assign lane_wdata = req_wdata << lane_shift;
  assign load_data  = (row_rdata >> lane_shift) & data_mask(req_size);

  dmem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_array (
    .clk     (clk),
    .clr     (reset),
    .row     (row_idx),
    .byte_en (byte_en),
    .wdata   (lane_wdata),
    .rdata   (row_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept edge: result captured here and held until the response handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rsp_rdata_p1 <= '0;
      rsp_err_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rsp_err_p1   <= req_err;
        rsp_rdata_p1 <= (req_err || req_write) ? '0 : load_data;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_p1;
  assign rsp_err   = rsp_err_p1;

endmodule
